// File: rtl/vram_pkg.sv
// Shared types for the VRAM port arbiter: read-tag owner and pipeline entry.
package vram_pkg;

  localparam int unsigned STARVE_CNT_W = 8;

  typedef enum logic {
    OWN_PPU = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Tracks outstanding reads: an RD_LAT-deep shift register of {valid, owner}.
// The last stage lines up with the cycle the RAM presents the read data.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  owner_e in_owner,
  output logic   out_valid,
  output owner_e out_owner
);

  rd_tag_t stage [RD_LAT];

  // Shift every cycle; reset drops every read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= '{valid: in_valid, owner: in_owner};
      for (int i = 1; i < int'(RD_LAT); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_valid = stage[RD_LAT-1].valid;
  assign out_owner = stage[RD_LAT-1].owner;

endmodule

// File: rtl/vram_port_arb.sv
// Single RAM port arbiter between a PPU read stream and a CPU read/write port.
// PPU has priority; the CPU is forced through after STARVE_MAX stalled cycles.
// One instance fronts each RAM port (tile, pattern, palette, sprite port A).
module vram_port_arb
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ppu_req,
  input  logic [ADDR_W-1:0]   ppu_addr,
  output logic                ppu_gnt,
  output logic                ppu_rvalid,
  output logic [DATA_W-1:0]   ppu_rdata,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wrdata,
  output logic [DATA_W/8-1:0] ram_byteena,
  output logic                ram_wren,
  input  logic [DATA_W-1:0]   ram_rddata
);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    starve_hit;
  logic                    tag_in_valid;
  owner_e                  tag_in_owner;
  logic                    tag_out_valid;
  owner_e                  tag_out_owner;
  logic [DATA_W-1:0]       ppu_hold;
  logic [DATA_W-1:0]       cpu_hold;

  assign starve_hit = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));

  // Same-cycle grants: PPU first unless the CPU has waited STARVE_MAX cycles.
  always_comb begin
    ppu_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (rst_n) begin
      ppu_gnt = ppu_req & ~starve_hit;
      cpu_gnt = cpu_req & (~ppu_req | starve_hit);
    end
  end

  // Count consecutive stalled CPU cycles, saturating at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (cpu_req && !cpu_gnt) begin
      if (!starve_hit) begin
        starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // RAM port driven straight from the granted requester; idle drives zeros.
  always_comb begin
    ram_addr    = '0;
    ram_wrdata  = '0;
    ram_byteena = '0;
    ram_wren    = 1'b0;
    if (cpu_gnt) begin
      ram_addr    = cpu_addr;
      ram_wren    = cpu_wr;
      ram_wrdata  = cpu_wr ? cpu_wdata : '0;
      ram_byteena = cpu_wr ? cpu_be : '1;
    end else if (ppu_gnt) begin
      ram_addr    = ppu_addr;
      ram_byteena = '1;
    end
  end

  // Only granted reads occupy a tag slot; writes enter as empty slots.
  always_comb begin
    tag_in_valid = ppu_gnt | (cpu_gnt & ~cpu_wr);
    tag_in_owner = cpu_gnt ? OWN_CPU : OWN_PPU;
  end

  vram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (tag_in_valid),
    .in_owner  (tag_in_owner),
    .out_valid (tag_out_valid),
    .out_owner (tag_out_owner)
  );

  assign ppu_rvalid = tag_out_valid & (tag_out_owner == OWN_PPU);
  assign cpu_rvalid = tag_out_valid & (tag_out_owner == OWN_CPU);

  // Remember the last returned word per requester so rdata holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_hold <= '0;
      cpu_hold <= '0;
    end else begin
      if (ppu_rvalid) ppu_hold <= ram_rddata;
      if (cpu_rvalid) cpu_hold <= ram_rddata;
    end
  end

  assign ppu_rdata = ppu_rvalid ? ram_rddata : ppu_hold;
  assign cpu_rdata = cpu_rvalid ? ram_rddata : cpu_hold;

endmodule

// File: tb/tb_vram_port_arb.sv
// Directed bench for vram_port_arb with a 2-cycle-latency byte-enabled RAM model.
module tb_vram_port_arb;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_gnt;
  logic              ppu_rvalid;
  logic [DATA_W-1:0] ppu_rdata;
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wrdata;
  logic [BE_W-1:0]   ram_byteena;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_rddata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_port_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .STARVE_MAX(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_gnt(ppu_gnt),
    .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_byteena(ram_byteena),
    .ram_wren(ram_wren), .ram_rddata(ram_rddata)
  );

  // RAM model: word i initialised to 0xA500_0000 | i, read data 2 cycles after address.
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] rd_d1, rd_d2;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
  end

  always @(posedge clk) begin
    rd_d1 <= mem[ram_addr];
    rd_d2 <= rd_d1;
    if (ram_wren) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
      end
    end
  end
  assign ram_rddata = rd_d2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ppu_req = 1'b0; ppu_addr = '0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ppu_req = 1'b1; ppu_addr = 10'h003;
    cpu_req = 1'b1; cpu_addr = 10'h004;
    sample();
    checks++; if (ppu_gnt !== 1'b0) begin errors++; $display("FAIL reset_ppu_gnt got %b want 0", ppu_gnt); end
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got %b want 0", cpu_gnt); end
    checks++; if ({ppu_rvalid, cpu_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", {ppu_rvalid, cpu_rvalid}); end
    checks++; if (ppu_rdata !== 32'h0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", ppu_rdata, cpu_rdata); end
    checks++; if (ram_addr !== '0 || ram_wren !== 1'b0 || ram_byteena !== '0) begin errors++; $display("FAIL reset_ram got addr %h wren %b be %b want 0", ram_addr, ram_wren, ram_byteena); end
    advance();
    idle_inputs();
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_ppu_read();
    ppu_req = 1'b1; ppu_addr = 10'h005;
    sample();
    checks++; if (ppu_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL ppu_rd_gnt got %b%b want 10", ppu_gnt, cpu_gnt); end
    checks++; if (ram_addr !== 10'h005 || ram_byteena !== 4'hF || ram_wren !== 1'b0) begin errors++; $display("FAIL ppu_rd_ram got addr %h be %b wren %b want 005 1111 0", ram_addr, ram_byteena, ram_wren); end
    advance();
    idle_inputs();
    sample();
    checks++; if (ppu_rvalid !== 1'b0 || ram_addr !== '0) begin errors++; $display("FAIL ppu_rd_t1 got rvalid %b addr %h want 0 000", ppu_rvalid, ram_addr); end
    advance();
    sample();
    checks++; if (ppu_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL ppu_rd_t2_valid got %b%b want 10", ppu_rvalid, cpu_rvalid); end
    checks++; if (ppu_rdata !== 32'hA500_0005) begin errors++; $display("FAIL ppu_rd_t2_data got %h want a5000005", ppu_rdata); end
    advance();
    sample();
    checks++; if (ppu_rvalid !== 1'b0 || ppu_rdata !== 32'hA500_0005) begin errors++; $display("FAIL ppu_rd_hold got %b %h want 0 a5000005", ppu_rvalid, ppu_rdata); end
    advance();
  endtask

  task automatic test_starvation();
    bit exp_cg, exp_pv, exp_cv;
    for (int k = 0; k < 18; k++) begin
      ppu_req = 1'b1; ppu_addr = 10'h020;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h030;
      sample();
      exp_cg = ((k % 9) == 8);
      exp_pv = (k >= 2) && (((k - 2) % 9) != 8);
      exp_cv = (k == 10);
      checks++; if (cpu_gnt !== exp_cg || ppu_gnt !== !exp_cg) begin errors++; $display("FAIL starve_gnt cycle %0d got ppu %b cpu %b want ppu %b cpu %b", k, ppu_gnt, cpu_gnt, !exp_cg, exp_cg); end
      checks++; if (ppu_rvalid !== exp_pv || cpu_rvalid !== exp_cv) begin errors++; $display("FAIL starve_rvalid cycle %0d got %b%b want %b%b", k, ppu_rvalid, cpu_rvalid, exp_pv, exp_cv); end
      if (exp_pv) begin
        checks++; if (ppu_rdata !== 32'hA500_0020) begin errors++; $display("FAIL starve_ppu_data cycle %0d got %h want a5000020", k, ppu_rdata); end
      end
      if (exp_cv) begin
        checks++; if (cpu_rdata !== 32'hA500_0030) begin errors++; $display("FAIL starve_cpu_data cycle %0d got %h want a5000030", k, cpu_rdata); end
      end
      advance();
    end
    idle_inputs();
    repeat (3) advance();
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h010; cpu_wdata = 32'hDEAD_BEEF; cpu_be = 4'b0011;
    sample();
    checks++; if (cpu_gnt !== 1'b1 || ram_wren !== 1'b1) begin errors++; $display("FAIL wr_gnt got gnt %b wren %b want 1 1", cpu_gnt, ram_wren); end
    checks++; if (ram_byteena !== 4'b0011 || ram_addr !== 10'h010 || ram_wrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_ram got be %b addr %h data %h want 0011 010 deadbeef", ram_byteena, ram_addr, ram_wrdata); end
    advance();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid cycle %0d got %b want 0", k, cpu_rvalid); end
      advance();
    end
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h010;
    sample();
    checks++; if (cpu_gnt !== 1'b1 || ram_wren !== 1'b0 || ram_byteena !== 4'hF) begin errors++; $display("FAIL wr_rd_gnt got gnt %b wren %b be %b want 1 0 1111", cpu_gnt, ram_wren, ram_byteena); end
    advance();
    idle_inputs();
    advance();
    sample();
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA500_BEEF) begin errors++; $display("FAIL wr_merge got %b %h want 1 a500beef", cpu_rvalid, cpu_rdata); end
    advance();
    advance();
  endtask

  task automatic test_alternating();
    int j;
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k < 6) begin
        if ((k % 2) == 0) begin ppu_req = 1'b1; ppu_addr = 10'h040 + 10'(k); end
        else begin cpu_req = 1'b1; cpu_addr = 10'h050 + 10'(k); end
      end
      sample();
      if (k < 6) begin
        checks++; if (ppu_gnt !== ((k % 2) == 0) || cpu_gnt !== ((k % 2) == 1)) begin errors++; $display("FAIL alt_gnt cycle %0d got %b%b", k, ppu_gnt, cpu_gnt); end
      end
      if (k >= 2) begin
        j = k - 2;
        checks++; if (ppu_rvalid !== ((j % 2) == 0) || cpu_rvalid !== ((j % 2) == 1)) begin errors++; $display("FAIL alt_rvalid cycle %0d got %b%b", k, ppu_rvalid, cpu_rvalid); end
        if ((j % 2) == 0) begin
          checks++; if (ppu_rdata !== 32'hA500_0040 + 32'(j)) begin errors++; $display("FAIL alt_ppu_data cycle %0d got %h want %h", k, ppu_rdata, 32'hA500_0040 + 32'(j)); end
          if (j >= 1) begin
            checks++; if (cpu_rdata !== 32'hA500_0050 + 32'(j - 1)) begin errors++; $display("FAIL alt_cpu_hold cycle %0d got %h want %h", k, cpu_rdata, 32'hA500_0050 + 32'(j - 1)); end
          end
        end else begin
          checks++; if (cpu_rdata !== 32'hA500_0050 + 32'(j)) begin errors++; $display("FAIL alt_cpu_data cycle %0d got %h want %h", k, cpu_rdata, 32'hA500_0050 + 32'(j)); end
          checks++; if (ppu_rdata !== 32'hA500_0040 + 32'(j - 1)) begin errors++; $display("FAIL alt_ppu_hold cycle %0d got %h want %h", k, ppu_rdata, 32'hA500_0040 + 32'(j - 1)); end
        end
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 3; k++) begin
      ppu_req = 1'b1; ppu_addr = 10'h007;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h008;
      sample();
      if (k == 2) begin
        checks++; if (ppu_rvalid !== 1'b1 || ppu_rdata !== 32'hA500_0007) begin errors++; $display("FAIL rst_pre_rvalid got %b %h want 1 a5000007", ppu_rvalid, ppu_rdata); end
      end
      advance();
    end
    rst_n = 1'b0;
    sample();
    checks++; if (dut.starve_cnt !== 8'd0) begin errors++; $display("FAIL rst_counter got %0d want 0", dut.starve_cnt); end
    checks++; if (ppu_gnt !== 1'b0 || cpu_gnt !== 1'b0 || ram_addr !== '0) begin errors++; $display("FAIL rst_gnt got %b%b addr %h want 00 000", ppu_gnt, cpu_gnt, ram_addr); end
    checks++; if (ppu_rvalid !== 1'b0 || ppu_rdata !== 32'h0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_out got %b %h %h want 0 0 0", ppu_rvalid, ppu_rdata, cpu_rdata); end
    advance();
    idle_inputs();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (ppu_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || ppu_rdata !== 32'h0) begin errors++; $display("FAIL rst_drop cycle %0d got %b%b %h want 00 0", k, ppu_rvalid, cpu_rvalid, ppu_rdata); end
      advance();
    end
  endtask

  task automatic test_withdraw();
    for (int k = 0; k < 7; k++) begin
      idle_inputs();
      if (k < 4) begin ppu_req = 1'b1; ppu_addr = 10'h060; end
      if (k < 3) begin cpu_req = 1'b1; cpu_addr = 10'h061; end
      sample();
      checks++; if (cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wd_cpu cycle %0d got gnt %b rvalid %b want 0 0", k, cpu_gnt, cpu_rvalid); end
      if (k < 5) begin
        checks++; if (dut.starve_cnt !== 8'((k < 4) ? k : 0)) begin errors++; $display("FAIL wd_counter cycle %0d got %0d want %0d", k, dut.starve_cnt, (k < 4) ? k : 0); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_ppu_read();
    test_starvation();
    test_cpu_write();
    test_alternating();
    test_reset_inflight();
    test_withdraw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_port_arb.md
VRAM_PORT_ARB -- requirements
Module: vram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32: RAM data width; must be a multiple of 8.
REQ-003 SHALL have parameter RD_LAT, default 2: RAM read latency in cycles, 1..4.
REQ-004 SHALL have parameter STARVE_MAX, default 8: maximum consecutive stalled CPU cycles, 1..255.
REQ-005 SHALL have the following ports, one clock and one reset; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- ppu_req  in  1  PPU read request valid.
- ppu_addr  in  ADDR_W  PPU read address.
- ppu_gnt  out  1  PPU request accepted this cycle.
- ppu_rvalid  out  1  PPU read data valid.
- ppu_rdata  out  DATA_W  PPU read data.
- cpu_req  in  1  CPU request valid.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_be  in  DATA_W/8  CPU byte enables.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- ram_addr  out  ADDR_W  RAM port address.
- ram_wrdata  out  DATA_W  RAM write data.
- ram_byteena  out  DATA_W/8  RAM byte enables.
- ram_wren  out  1  RAM write enable.
- ram_rddata  in  DATA_W  RAM read data, valid RD_LAT cycles after the address.

Function
REQ-006 SHALL accept at most one request per cycle; a request is accepted when req and gnt are both 1 in the same cycle.
REQ-007 SHALL compute the grants combinationally in the same cycle as the request, with no bubble.
REQ-008 SHALL grant PPU when ppu_req=1, unless the starvation counter equals STARVE_MAX.
REQ-009 SHALL grant CPU when cpu_req=1 and either ppu_req=0 or the starvation counter equals STARVE_MAX.
REQ-010 SHALL keep a starvation counter, 8 bits wide, saturating at STARVE_MAX.
- Increments each cycle in which cpu_req=1 and cpu_gnt=0.
- Clears to 0 on any cycle with cpu_gnt=1 or cpu_req=0.
REQ-011 SHALL stall PPU for exactly one cycle on a forced CPU grant; PPU regains priority on the next cycle.
REQ-012 SHALL drive the RAM outputs directly from the granted requester in the grant cycle.
- ram_wren = cpu_gnt & cpu_wr.
- ram_byteena = cpu_be during a CPU write, otherwise all ones.
REQ-013 SHALL drive ram_addr, ram_wrdata, ram_byteena and ram_wren to 0 when no grant is issued.
REQ-014 SHALL track outstanding reads in an RD_LAT-deep shift register of {valid, owner}.
- Shifts every cycle.
- Entry is loaded on a granted read; a CPU write loads valid=0.
REQ-015 SHALL pulse the owner's rvalid for one cycle exactly RD_LAT cycles after its grant.
- The owner's rdata equals ram_rddata in that cycle.
REQ-016 SHALL hold the rdata of the non-owning requester at its last value.
REQ-017 SHALL preserve order; back-to-back reads return back-to-back at full throughput.
REQ-018 SHALL treat a CPU write followed by a CPU read to the same address as RAM-defined; no internal forwarding.
REQ-019 SHALL tolerate a requester deasserting req without a grant; no state is kept for unaccepted requests.

Reset
REQ-020 SHALL, on rst_n=0 asynchronously, clear the starvation counter, all pipeline valids, ppu_rvalid, cpu_rvalid, ppu_rdata and cpu_rdata to 0.
REQ-021 SHALL drop any read in flight at reset; it produces no rvalid after reset release.
REQ-022 SHALL hold all grants at 0 while rst_n=0.

Structure
REQ-023 SHALL place the owner enum (OWN_PPU, OWN_CPU) and the pipeline-entry struct in the shared package vram_pkg.
REQ-024 SHALL implement the tag pipeline as sub-module vram_rd_tag_pipe.
- Parameterised by RD_LAT.
- Inputs: valid and owner; outputs: valid and owner.
REQ-025 SHALL provide one instance per RAM port; tile, pattern, palette and sprite port A are each fronted by their own instance.

Verification
REQ-026 SHALL check: ppu_req=1 at addr 0x005, cpu_req=0 -> ppu_gnt=1 at T0, ram_addr=0x005, ppu_rvalid=1 at T0+2 with ppu_rdata = model[0x005].
REQ-027 SHALL check: both requesting continuously, STARVE_MAX=8 -> cpu_gnt=1 on the 9th cycle only, ppu_gnt=0 that cycle, pattern repeats every 9 cycles.
REQ-028 SHALL check: CPU write addr 0x010, data 0xDEADBEEF, be=4'b0011 -> ram_wren=1, ram_byteena=0011, no cpu_rvalid follows; a later read returns the merged bytes.
REQ-029 SHALL check: alternating PPU/CPU reads every cycle -> rvalid pulses alternate owners in issue order with no lost or duplicated data.
REQ-030 SHALL check: rst_n low one cycle after a PPU read grant -> no ppu_rvalid after release; counter and outputs are 0.
REQ-031 SHALL check: cpu_req asserted then withdrawn after 3 stalled cycles -> counter returns to 0, no grant issued.
